// File: rtl/dmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ctrl
//   Load/store sequencer between the core's memory stage and a word-addressed
//   data memory that supports only full-word writes and combinational reads.
//   Handles one B/H/W request at a time:
//     - loads: one read cycle, then a sign- or zero-extended response
//     - SW: one write cycle, then a response
//     - SB/SH: read-modify-write (read cycle, write cycle), then a response
//     - illegal requests: immediate error response with no memory access
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   When defined, misaligned H/HU/SH (addr[0]=1) and W/SW (addr[1:0]!=0) are
//   rejected with o_resp_err=1. When undefined, low offset bits are simply
//   truncated and the access proceeds.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_*               request handshake (valid/ready), we, funct3, addr, wdata
//   o_resp_*              response handshake (valid/ready), rdata, err
//   o_mem_addr/wd/wen/ren memory strobes; o_mem_addr is word-aligned
//   i_mem_rd              combinational memory read word
// -----------------------------------------------------------------------------
module dmem_lsu_ctrl #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [2:0]           i_req_funct3,
    input  logic [WORD_SIZE-1:0] i_req_addr,
    input  logic [WORD_SIZE-1:0] i_req_wdata,
    output logic                 o_resp_valid,
    input  logic                 i_resp_ready,
    output logic [WORD_SIZE-1:0] o_resp_rdata,
    output logic                 o_resp_err,
    output logic [WORD_SIZE-1:0] o_mem_addr,
    output logic [WORD_SIZE-1:0] o_mem_wd,
    output logic                 o_mem_wen,
    output logic                 o_mem_ren,
    input  logic [WORD_SIZE-1:0] i_mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t               state_q,  state_d;
    logic [WORD_SIZE-1:0] addr_q,   addr_d;
    logic                 we_q,     we_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [WORD_SIZE-1:0] wdata_q,  wdata_d;
    logic [WORD_SIZE-1:0] merge_q,  merge_d;
    logic [WORD_SIZE-1:0] rdata_q,  rdata_d;
    logic                 err_q,    err_d;

    // Request legality: unsupported funct3 encodings, plus optional alignment.
    function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
        logic bad;
        if (we) bad = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
        else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
`ifdef LSU_MISALIGN_CHECK_EN
        if (!bad) begin
            if (f3[1:0] == 2'b01 && off[0])        bad = 1'b1;
            if (f3[1:0] == 2'b10 && off != 2'b00)  bad = 1'b1;
        end
`else
        if (off == 2'b11) bad = bad;  // offset does not affect legality here
`endif
        return bad;
    endfunction

    // Extract the addressed byte/half lane and extend; f3[2] selects zero-extension.
    function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Replace the target byte/half lane of the read word with store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] rd, input logic [31:0] wd,
                                               input logic f3_half, input logic [1:0] off);
        logic [31:0] m;
        m = rd;
        if (!f3_half)    m[{off, 3'b000} +: 8] = wd[7:0];
        else if (off[1]) m[31:16] = wd[15:0];
        else             m[15:0]  = wd[15:0];
        return m;
    endfunction

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_mem_wen    = 1'b0;
        o_mem_ren    = 1'b0;
        o_mem_wd     = '0;

        case (state_q)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    addr_d   = i_req_addr;
                    we_d     = i_req_we;
                    funct3_d = i_req_funct3;
                    wdata_d  = i_req_wdata;
                    rdata_d  = '0;
                    err_d    = req_illegal(i_req_we, i_req_funct3, i_req_addr[1:0]);
                    state_d  = err_d ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    o_mem_ren = 1'b1;
                    rdata_d   = load_ext(i_mem_rd, funct3_q, addr_q[1:0]);
                    state_d   = S_RESP;
                end else if (funct3_q == 3'b010) begin
                    o_mem_wen = 1'b1;
                    o_mem_wd  = wdata_q;
                    state_d   = S_RESP;
                end else begin
                    // Sub-word store: read the word now, write the merged word next cycle.
                    o_mem_ren = 1'b1;
                    merge_d   = merge_lane(i_mem_rd, wdata_q, funct3_q[0], addr_q[1:0]);
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                o_mem_wen = 1'b1;
                o_mem_wd  = merge_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_mem_addr   = {addr_q[WORD_SIZE-1:2], 2'b00};
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the word-addressed data memory.
- The data memory supports only full-word writes and combinational word reads.
- This block accepts one byte, halfword or word request at a time. It issues the memory Ren/Wen strobes, performs read-modify-write for SB/SH, and returns sign- or zero-extended load data through a valid/ready response handshake.

Parameters:
- WORD_SIZE, 32, data and address width in bits (fixed at 32 for this block).

Ports:
- i_clk  input  1  clock; all state changes on rising edge
- i_rst  input  1  synchronous active-high reset
- i_req_valid  input  1  request present
- o_req_ready  output  1  block can accept a request (high only in IDLE)
- i_req_we  input  1  1 = store, 0 = load
- i_req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_req_addr  input  WORD_SIZE  byte address
- i_req_wdata  input  WORD_SIZE  store data; low bits are used for B/H
- o_resp_valid  output  1  response available
- i_resp_ready  input  1  consumer accepts response
- o_resp_rdata  output  WORD_SIZE  extended load data (0 for stores)
- o_resp_err  output  1  request rejected (illegal funct3, or misaligned when the feature is enabled)
- o_mem_addr  output  WORD_SIZE  byte address to memory, low 2 bits forced to 0
- o_mem_wd  output  WORD_SIZE  write word
- o_mem_wen  output  1  memory write enable
- o_mem_ren  output  1  memory read enable
- i_mem_rd  input  WORD_SIZE  memory read word (combinational, valid same cycle as o_mem_ren)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state=IDLE, o_req_ready=1, o_resp_valid=0, o_resp_rdata=0, o_resp_err=0, o_mem_wen=0, o_mem_ren=0, o_mem_addr=0, o_mem_wd=0.
- Request capture: on acceptance (i_req_valid & o_req_ready), addr, we, funct3 and wdata are registered. Inputs are don't-care afterwards.
- Byte offset and lanes: off = addr[1:0]. Byte lane = off. Halfword lane = off[1].
- State IDLE: o_req_ready=1. On accept, go to ACCESS, or to RESP with err=1 if the request is illegal.
- State ACCESS:
  - Load: o_mem_ren=1. Select byte/half from i_mem_rd at the lane, sign-extend (B/H) or zero-extend (BU/HU), register into o_resp_rdata. Go to RESP.
  - SW: o_mem_wen=1, o_mem_wd=wdata. Go to RESP.
  - SB/SH: o_mem_ren=1. Register i_mem_rd into the merge register with the target lane replaced by wdata[7:0] or wdata[15:0]. Go to WRITE.
- State WRITE: o_mem_wen=1, o_mem_wd=merge register, o_mem_ren=0. Go to RESP.
- State RESP: o_resp_valid=1, holding rdata and err stable. When i_resp_ready=1, return to IDLE.
  - A new request is not accepted in the same cycle (o_req_ready=0 in RESP).
- Strobes: o_mem_wen and o_mem_ren are never both 1 in the same cycle. Both are 0 outside ACCESS/WRITE.
- Latency (accept at edge N):
  - load/SW: memory access cycle N+1, o_resp_valid from N+2.
  - SB/SH: write cycle N+2, o_resp_valid from N+3.
  - Illegal: o_resp_valid from N+1, no memory strobe.
- Illegal funct3:
  - loads: 011, 110, 111.
  - stores: any funct3 other than 000/001/010.
  - Response: err=1, rdata=0.
- Stores return rdata=0, err=0.
- Reset mid-operation (ACCESS/WRITE): the state is abandoned with no further strobes after the reset edge. A pending RMW write is not issued.
- Backpressure: the block may hold RESP indefinitely. All outputs are stable while o_resp_valid=1 and i_resp_ready=0.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: H/HU/SH with off[0]=1, or W/SW with off≠0, is rejected with err=1 and no memory access.
- Undefined: no misalignment error. Offsets are truncated (halfword uses off[1], word ignores off) and the access proceeds normally.

Test Plan:
- Memory word 0x10 = 0x8899AABB. LB addr 0x13 → rdata 0xFFFFFF88, err=0, resp at N+2. LBU addr 0x12 → 0x00000099.
- Memory word 0x20 = 0x11223344. SB addr 0x21 wdata 0x000000EE → one ren cycle, then wen with o_mem_wd=0x1122EE44 at o_mem_addr=0x20. Resp at N+3, memory now 0x1122EE44.
- SH addr 0x22 wdata 0xCAFE onto 0x11223344 → o_mem_wd=0xCAFE3344. LH addr 0x22 → 0xFFFFCAFE. LHU → 0x0000CAFE.
- SW addr 0x30 wdata 0xDEADBEEF with i_resp_ready=0 for 5 cycles → single wen pulse, o_resp_valid held 5 cycles, then one cycle of handshake, then o_req_ready=1.
- Load with funct3=011 → err=1, rdata=0, no ren/wen, resp at N+1. With LSU_MISALIGN_CHECK_EN, LW addr 0x31 → err=1, no strobe. Without it, the same LW reads word 0x30.
- Assert i_rst in the WRITE-pending cycle of an SB (during ACCESS) → no wen ever issued, memory unchanged, all outputs at reset values next cycle.
